// File: rtl/s1_distributor.sv
// rtl/s1_distributor.sv - Spreads an N-bit word stream into four registered lanes Q0..Q3.
// Optional S1_DIST_ADDR_EN selects addressed lanes ({A1|B1, A0&B0}) instead of round-robin.
module s1_distributor #(
  parameter int N = 1
) (
  input  logic         clk,
  input  logic         clr,
  input  logic [N-1:0] din,
  input  logic         din_valid,
  output logic         din_ready,
  output logic [N-1:0] Q0,
  output logic [N-1:0] Q1,
  output logic [N-1:0] Q2,
  output logic [N-1:0] Q3,
  output logic         out_valid,
  input  logic         out_ready,
  input  logic         A1,
  input  logic         B1,
  input  logic         A0,
  input  logic         B0
);

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [3:0]          mask_q, mask_d;
  logic [3:0][N-1:0]   lanes_q, lanes_d;
  logic [1:0]          lane;
  logic [3:0]          lane_oh;
  logic                xfer;
  logic                release_set;

`ifdef S1_DIST_ADDR_EN
  assign lane = {A1 | B1, A0 & B0};
`else
  logic [1:0] cnt_q, cnt_d;
  // Address inputs have no role in round-robin mode.
  logic unused_addr;
  assign unused_addr = A1 ^ B1 ^ A0 ^ B0;
  assign lane = cnt_q;
`endif

  assign lane_oh     = 4'b0001 << lane;
  assign xfer        = din_valid & din_ready;
  assign release_set = (state_q == FULL) & out_ready;

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= FILL;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL: if (xfer && ((mask_q | lane_oh) == 4'b1111)) state_d = FULL;
      FULL: if (out_ready) state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  always_comb begin
    din_ready = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      FILL: din_ready = 1'b1;
      FULL: out_valid = 1'b1;
      default: din_ready = 1'b0;
    endcase
  end

  // Consuming a set clears the fill bookkeeping but keeps the lane data visible.
  always_comb begin
    mask_d  = mask_q;
    lanes_d = lanes_q;
    if (xfer) begin
      mask_d        = mask_q | lane_oh;
      lanes_d[lane] = din;
    end else if (release_set) begin
      mask_d = 4'b0000;
    end
  end

`ifndef S1_DIST_ADDR_EN
  always_comb begin
    cnt_d = cnt_q;
    if (xfer) begin
      cnt_d = cnt_q + 2'd1;
    end else if (release_set) begin
      cnt_d = 2'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt_q <= 2'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (clr) begin
      mask_q  <= 4'b0000;
      lanes_q <= '0;
    end else begin
      mask_q  <= mask_d;
      lanes_q <= lanes_d;
    end
  end

  assign Q0 = lanes_q[0];
  assign Q1 = lanes_q[1];
  assign Q2 = lanes_q[2];
  assign Q3 = lanes_q[3];

endmodule

// File: tb/tb_s1_distributor.sv
// tb/tb_s1_distributor.sv - Scoreboard bench for s1_distributor against a behavioural lane model.
module tb_s1_distributor;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         clr;
  logic [N-1:0] din;
  logic         din_valid;
  logic         din_ready;
  logic [N-1:0] Q0, Q1, Q2, Q3;
  logic         out_valid;
  logic         out_ready;
  logic         A1, B1, A0, B0;

  always #5 clk = ~clk;

  s1_distributor #(.N(N)) dut (
    .clk(clk), .clr(clr), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .Q0(Q0), .Q1(Q1), .Q2(Q2), .Q3(Q3), .out_valid(out_valid), .out_ready(out_ready),
    .A1(A1), .B1(B1), .A0(A0), .B0(B0)
  );

  typedef struct packed {
    logic [3:0][N-1:0] q;
    logic [3:0]        mask;
    logic              ov;
    logic              rdy;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  logic [N-1:0] m_lane[4];
  bit           m_fill[4];
  bit           m_full;
  int           m_rr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic step(input bit c, input bit v, input logic [N-1:0] d, input bit ordy,
                      input bit a1, input bit b1, input bit a0, input bit b0);
    exp_t e;
    int   ln;
    bool_all: begin end
    @(negedge clk);
    clr = c; din_valid = v; din = d; out_ready = ordy;
    A1 = a1; B1 = b1; A0 = a0; B0 = b0;
    if (c) begin
      for (int i = 0; i < 4; i++) begin m_lane[i] = '0; m_fill[i] = 0; end
      m_full = 0; m_rr = 0;
    end else if (m_full) begin
      if (ordy) begin
        for (int i = 0; i < 4; i++) m_fill[i] = 0;
        m_full = 0; m_rr = 0;
      end
    end else if (v) begin
`ifdef S1_DIST_ADDR_EN
      ln = ((a1 | b1) ? 2 : 0) + ((a0 & b0) ? 1 : 0);
`else
      ln = m_rr;
`endif
      m_lane[ln] = d;
      m_fill[ln] = 1;
      m_rr = (m_rr + 1) % 4;
      m_full = m_fill[0] && m_fill[1] && m_fill[2] && m_fill[3];
    end
    for (int i = 0; i < 4; i++) begin
      e.q[i]    = m_lane[i];
      e.mask[i] = m_fill[i];
    end
    e.ov  = m_full;
    e.rdy = !m_full;
    exp_q.push_back(e);
  endtask

  task automatic rr(input bit v, input logic [N-1:0] d, input bit ordy);
    step(0, v, d, ordy, 0, 0, 0, 0);
  endtask

  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("Q0", 32'(Q0), 32'(e.q[0]));
      chk("Q1", 32'(Q1), 32'(e.q[1]));
      chk("Q2", 32'(Q2), 32'(e.q[2]));
      chk("Q3", 32'(Q3), 32'(e.q[3]));
      chk("mask", 32'(dut.mask_q), 32'(e.mask));
      chk("out_valid", 32'(out_valid), 32'(e.ov));
      chk("din_ready", 32'(din_ready), 32'(e.rdy));
    end
  end

  initial begin
    int budget;
    clr = 1; din = '0; din_valid = 0; out_ready = 0;
    A1 = 0; B1 = 0; A0 = 0; B0 = 0;

    // Reset state
    step(1, 0, 0, 0, 0, 0, 0, 0);
`ifdef S1_DIST_ADDR_EN
    step(0, 1, 4'hA, 0, 0, 1, 1, 1);
    step(0, 1, 4'h1, 0, 0, 0, 0, 0);
    step(0, 1, 4'h2, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 4'h5, 0, 1, 0, 0, 1);
    step(0, 1, 4'h6, 0, 0, 0, 1, 1);
    step(0, 1, 4'h7, 0, 0, 0, 0, 0);
    step(0, 1, 4'h8, 1, 1, 1, 1, 1);
    step(0, 0, 0, 1, 0, 0, 0, 0);
`else
    rr(1, 1, 0); rr(1, 0, 0); rr(1, 1, 0); rr(1, 1, 0);
    for (int i = 0; i < 5; i++) rr(1, 0, 0);
    rr(0, 0, 1);
    rr(1, 4'h9, 0);
    rr(1, 4'h3, 0);
    step(1, 1, 4'hF, 1, 0, 0, 0, 0);
    rr(1, 4'hC, 0);
`endif
    for (int i = 0; i < 10; i++) step(0, 0, 4'(i), 1, 1, 1, 1, 1);

    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 49) == 0), $urandom_range(0, 3) != 0, 4'($urandom),
           $urandom_range(0, 2) == 0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    end

    budget = 0;
    while (exp_q.size() > 0 && budget < 10) begin
      @(negedge clk);
      budget++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
